// File: rtl/mips_isa_pkg.sv
// MIPS load/store opcode encodings and the MEM-stage FSM state type.
package mips_isa_pkg;

  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_SW  = 6'd4;
  localparam logic [5:0] OP_LH  = 6'd5;
  localparam logic [5:0] OP_LHU = 6'd6;
  localparam logic [5:0] OP_LB  = 6'd7;
  localparam logic [5:0] OP_LBU = 6'd8;
  localparam logic [5:0] OP_SH  = 6'd9;
  localparam logic [5:0] OP_SB  = 6'd10;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational access decode: byte enables, replicated write data, alignment
// check and little-endian load extraction with sign/zero extension.
module lsu_align import mips_isa_pkg::*; #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 6
) (
  input  logic [OP_W-1:0]             opcode,
  input  logic [$clog2(DATA_W/8)-1:0] lane,
  input  logic [DATA_W-1:0]           store_data,
  input  logic [DATA_W-1:0]           rdata,
  output logic [DATA_W/8-1:0]         be,
  output logic [DATA_W-1:0]           wdata,
  output logic [DATA_W-1:0]           load_data,
  output logic                        is_mem,
  output logic                        is_load,
  output logic                        misalign
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted   = rdata >> {lane, 3'b000};
    be        = '0;
    wdata     = '0;
    load_data = '0;
    is_mem    = 1'b1;
    is_load   = 1'b0;
    misalign  = 1'b0;
    case (opcode)
      OP_W'(OP_LW): begin
        is_load   = 1'b1;
        misalign  = |lane[1:0];
        be        = BE_W'(4'hF) << lane;
        load_data = DATA_W'(shifted[31:0]);
      end
      OP_W'(OP_LH): begin
        is_load   = 1'b1;
        misalign  = lane[0];
        be        = BE_W'(2'b11) << lane;
        load_data = DATA_W'($signed(shifted[15:0]));
      end
      OP_W'(OP_LHU): begin
        is_load   = 1'b1;
        misalign  = lane[0];
        be        = BE_W'(2'b11) << lane;
        load_data = DATA_W'(shifted[15:0]);
      end
      OP_W'(OP_LB): begin
        is_load   = 1'b1;
        be        = BE_W'(1'b1) << lane;
        load_data = DATA_W'($signed(shifted[7:0]));
      end
      OP_W'(OP_LBU): begin
        is_load   = 1'b1;
        be        = BE_W'(1'b1) << lane;
        load_data = DATA_W'(shifted[7:0]);
      end
      OP_W'(OP_SW): begin
        misalign = |lane[1:0];
        be       = BE_W'(4'hF) << lane;
        wdata    = {(BE_W/4){store_data[31:0]}};
      end
      OP_W'(OP_SH): begin
        misalign = lane[0];
        be       = BE_W'(2'b11) << lane;
        wdata    = {(BE_W/2){store_data[15:0]}};
      end
      OP_W'(OP_SB): begin
        be    = BE_W'(1'b1) << lane;
        wdata = {BE_W{store_data[7:0]}};
      end
      default: is_mem = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MIPS MEM stage: load/store unit on a req/gnt/rvalid port with bus timeout,
// producing a registered one-cycle MEM/WB result pulse.
module mem_stage_lsu import mips_isa_pkg::*; #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned OP_W    = 6,
  parameter int unsigned TMO_CYC = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     opcode,
  input  logic [REG_AW-1:0]   src,
  input  logic [REG_AW-1:0]   dest,
  input  logic [REG_AW-1:0]   target,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic [DATA_W-1:0]   alu_src,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                out_valid,
  output logic [OP_W-1:0]     out_opcode,
  output logic [REG_AW-1:0]   out_src,
  output logic [REG_AW-1:0]   out_dest,
  output logic [REG_AW-1:0]   out_target,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_misalign,
  output logic                out_buserr
);
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(BE_W);
  localparam int unsigned TMO_W  = $clog2(TMO_CYC + 1);
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(BE_W - 1);

  lsu_state_e        state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              abort;
  logic [OP_W-1:0]   op_q;
  logic [REG_AW-1:0] src_q, dest_q, target_q;
  logic [DATA_W-1:0] alu_q, st_q, ld_q;
  logic              mis_q, err_q;

  logic [OP_W-1:0]   a_op;
  logic [LANE_W-1:0] a_lane;
  logic [BE_W-1:0]   a_be;
  logic [DATA_W-1:0] a_wdata, a_ldata;
  logic              a_mem, a_load, a_mis;

  // While idle the decoder looks at the incoming op so the accept edge can
  // choose REQ vs RESP; afterwards it decodes the captured op.
  assign a_op   = (state_q == IDLE) ? opcode : op_q;
  assign a_lane = (state_q == IDLE) ? alu_out[LANE_W-1:0] : alu_q[LANE_W-1:0];

  lsu_align #(.DATA_W(DATA_W), .OP_W(OP_W)) u_align (
    .opcode    (a_op),
    .lane      (a_lane),
    .store_data(st_q),
    .rdata     (mem_rdata),
    .be        (a_be),
    .wdata     (a_wdata),
    .load_data (a_ldata),
    .is_mem    (a_mem),
    .is_load   (a_load),
    .misalign  (a_mis)
  );

  assign in_ready  = (state_q == IDLE);
  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req & ~a_load;
  assign mem_be    = mem_req ? a_be : '0;
  assign mem_wdata = mem_we ? a_wdata : '0;
  assign mem_addr  = mem_req ? (ADDR_W'(alu_q) & ~LANE_MASK) : '0;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    abort   = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = (a_mem && !a_mis) ? REQ : RESP;
        tmo_d   = '0;
      end
      REQ: if (mem_gnt) begin
        state_d = a_load ? WAIT : RESP;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_d == TMO_W'(TMO_CYC)) begin
          abort   = 1'b1;
          state_d = RESP;
        end
      end
      WAIT: if (mem_rvalid) begin
        state_d = RESP;
      end else begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_d == TMO_W'(TMO_CYC)) begin
          abort   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      tmo_q        <= '0;
      op_q         <= '0;
      src_q        <= '0;
      dest_q       <= '0;
      target_q     <= '0;
      alu_q        <= '0;
      st_q         <= '0;
      ld_q         <= '0;
      mis_q        <= 1'b0;
      err_q        <= 1'b0;
      out_valid    <= 1'b0;
      out_opcode   <= '0;
      out_src      <= '0;
      out_dest     <= '0;
      out_target   <= '0;
      out_data     <= '0;
      out_misalign <= 1'b0;
      out_buserr   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      out_valid <= 1'b0;
      if (state_q == IDLE && in_valid) begin
        op_q     <= opcode;
        src_q    <= src;
        dest_q   <= dest;
        target_q <= target;
        alu_q    <= alu_out;
        st_q     <= alu_src;
        mis_q    <= a_mem & a_mis;
        err_q    <= 1'b0;
      end
      if (state_q == WAIT && mem_rvalid) ld_q <= a_ldata;
      if (abort) err_q <= 1'b1;
      if (state_q == RESP) begin
        out_valid    <= 1'b1;
        out_opcode   <= op_q;
        out_src      <= src_q;
        out_dest     <= dest_q;
        out_target   <= target_q;
        out_data     <= err_q ? '0 : ((a_load && !mis_q) ? ld_q : alu_q);
        out_misalign <= mis_q;
        out_buserr   <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a spec-level model predicts each result,
// its latency and the memory request; one negedge process compares against it.
module tb_mem_stage_lsu;
  import mips_isa_pkg::*;

  localparam int TMO = 15;

  logic        clk = 1'b0, reset = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [5:0]  opcode = '0;
  logic [4:0]  src = '0, dest = '0, target = '0;
  logic [31:0] alu_out = '0, alu_src = '0;
  logic        mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_be;
  logic        out_valid, out_misalign, out_buserr;
  logic [5:0]  out_opcode;
  logic [4:0]  out_src, out_dest, out_target;
  logic [31:0] out_data;

  always #5 clk = ~clk;

  mem_stage_lsu #(.DATA_W(32), .ADDR_W(32), .REG_AW(5), .OP_W(6), .TMO_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .src(src), .dest(dest), .target(target),
    .alu_out(alu_out), .alu_src(alu_src),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_opcode(out_opcode), .out_src(out_src), .out_dest(out_dest),
    .out_target(out_target), .out_data(out_data), .out_misalign(out_misalign),
    .out_buserr(out_buserr)
  );

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  src, dest, target;
    logic [31:0] data;
    logic        mis, err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        q[$];
  exp_t        ce;
  int          checks = 0, errors = 0, edge_n = 0;
  logic        cur_mem = 1'b0, cur_we = 1'b0;
  logic [31:0] cur_addr = '0, cur_wdata = '0;
  logic [3:0]  cur_be = '0;
  logic [31:0] seen_addr = '0, seen_wdata = '0, last_data = '0;
  logic [3:0]  seen_be = '0;
  logic        seen_we = 1'b0, last_mis = 1'b0, last_err = 1'b0;
  int          last_lat = 0, req_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int op_size(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:          return 4;
      OP_LH, OP_LHU, OP_SH:  return 2;
      OP_LB, OP_LBU, OP_SB:  return 1;
      default:               return 0;
    endcase
  endfunction

  function automatic bit op_load(input logic [5:0] op);
    return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
  endfunction

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (reset) begin
      if (mem_req) begin
        req_cnt++;
        chk("mem_req", 32'(mem_req), 32'(cur_mem));
        chk("mem_addr", mem_addr, cur_addr);
        chk("mem_be", 32'(mem_be), 32'(cur_be));
        chk("mem_we", 32'(mem_we), 32'(cur_we));
        if (cur_we) chk("mem_wdata", mem_wdata, cur_wdata);
        seen_addr = mem_addr; seen_be = mem_be; seen_we = mem_we; seen_wdata = mem_wdata;
      end
      if (out_valid) begin
        if (q.size() == 0) chk("out_valid_spurious", 32'(out_valid), 32'd0);
        else begin
          ce = q.pop_front();
          chk("out_opcode", 32'(out_opcode), 32'(ce.op));
          chk("out_src", 32'(out_src), 32'(ce.src));
          chk("out_dest", 32'(out_dest), 32'(ce.dest));
          chk("out_target", 32'(out_target), 32'(ce.target));
          chk("out_data", out_data, ce.data);
          chk("out_misalign", 32'(out_misalign), 32'(ce.mis));
          chk("out_buserr", 32'(out_buserr), 32'(ce.err));
          chk("latency", 32'(edge_n - ce.acc), 32'(ce.lat));
          chk("in_ready_at_out", 32'(in_ready), 32'd1);
          last_data = out_data; last_mis = out_misalign; last_err = out_buserr;
          last_lat = edge_n - ce.acc;
        end
      end
    end
  end

  task automatic wait_ready();
    int w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  // gd: idle cycles before gnt; rdl: idle cycles between gnt and rvalid.
  task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] s,
                       input logic [31:0] rd, input int gd, input int rdl, input bit stray,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rg);
    int sz, lane, lat, last, exp_req;
    bit ld, mis, ok, err;
    logic [31:0] mask, v;
    logic [3:0]  b;
    exp_t e;
    sz = op_size(op); ld = op_load(op); lane = int'(a[1:0]);
    mis = (sz != 0) && (lane % sz != 0);
    ok = (sz != 0) && !mis;
    err = 1'b0;
    if (!ok) lat = 2;
    else if (gd >= TMO) begin err = 1'b1; lat = TMO + 2; end
    else if (!ld) lat = 3 + gd;
    else if (rdl >= TMO) begin err = 1'b1; lat = 3 + gd + TMO; end
    else lat = 4 + gd + rdl;
    exp_req = !ok ? 0 : (gd >= TMO) ? TMO : gd + 1;
    mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
    v = (rd >> (8 * lane)) & mask;
    if ((op == OP_LB || op == OP_LH) && v[8*sz-1]) v = v | ~mask;
    b = 4'((1 << sz) - 1);
    e.op = op; e.src = rs; e.dest = rt; e.target = rg; e.mis = mis; e.err = err; e.lat = lat;
    e.data = err ? 32'h0 : (ok && ld) ? v : a;
    wait_ready();
    cur_mem = ok; cur_we = !ld; cur_addr = a & ~32'h3; cur_be = b << lane;
    cur_wdata = (sz == 1) ? s[7:0] * 32'h0101_0101 : (sz == 2) ? s[15:0] * 32'h0001_0001 : s;
    in_valid = 1'b1; opcode = op; alu_out = a; alu_src = s; src = rs; dest = rt; target = rg;
    e.acc = edge_n; q.push_back(e); req_cnt = 0;
    @(posedge clk); #1 in_valid = 1'b0;
    last = lat;
    if (ok && 1 + gd > last) last = 1 + gd;
    if (ok && ld && 2 + gd + rdl > last) last = 2 + gd + rdl;
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      mem_gnt    = ok && (k == 1 + gd);
      mem_rvalid = ok && ld && ((k == 2 + gd + rdl) || (stray && k == 1));
      mem_rdata  = (k == 2 + gd + rdl) ? rd : 32'h5A5A_0F0F;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; cur_mem = 1'b0;
    chk("result_pending", 32'(q.size()), 32'd0);
    q.delete();
    chk("req_cycles", 32'(req_cnt), 32'(exp_req));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_flags", 32'({out_misalign, out_buserr, mem_we}), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    do_op(6'd0, 32'h1234, 32'h0, 32'h0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
    chk("lit_add_data", last_data, 32'h1234);
    chk("lit_add_lat", 32'(last_lat), 32'd2);

    do_op(OP_LB, 32'h103, 32'h0, 32'h80FF_FF00, 0, 0, 0, 5'd4, 5'd5, 5'd6);
    chk("lit_lb_be", 32'(seen_be), 32'b1000);
    chk("lit_lb_data", last_data, 32'hFFFF_FF80);

    do_op(OP_SH, 32'h102, 32'hDEAD_BEEF, 32'h0, 1, 0, 0, 5'd7, 5'd8, 5'd9);
    chk("lit_sh_we", 32'(seen_we), 32'd1);
    chk("lit_sh_be", 32'(seen_be), 32'b1100);
    chk("lit_sh_wdata", seen_wdata, 32'hBEEF_BEEF);
    chk("lit_sh_addr", seen_addr, 32'h100);

    do_op(OP_LW, 32'h101, 32'h0, 32'h0, 0, 0, 0, 5'd10, 5'd11, 5'd12);
    chk("lit_lw_mis", 32'(last_mis), 32'd1);
    chk("lit_lw_mis_data", last_data, 32'h101);
    chk("lit_lw_mis_req", 32'(req_cnt), 32'd0);

    do_op(OP_LW, 32'h200, 32'h0, 32'h1357_9BDF, 0, TMO + 3, 0, 5'd13, 5'd14, 5'd15);
    chk("lit_tmo_err", 32'(last_err), 32'd1);
    chk("lit_tmo_data", last_data, 32'h0);
    chk("lit_tmo_lat", 32'(last_lat), 32'd18);

    do_op(OP_LBU, 32'h101, 32'h0, 32'h1234_8056, 2, 1, 1, 5'd16, 5'd17, 5'd18);
    chk("lit_lbu_data", last_data, 32'h80);
    do_op(OP_LHU, 32'h102, 32'h0, 32'h8001_0000, 0, 3, 0, 5'd19, 5'd20, 5'd21);
    chk("lit_lhu_data", last_data, 32'h8001);
    do_op(OP_LH, 32'h102, 32'h0, 32'h8001_0000, 1, 0, 0, 5'd22, 5'd23, 5'd24);
    chk("lit_lh_data", last_data, 32'hFFFF_8001);
    do_op(OP_LW, 32'h204, 32'h0, 32'hCAFE_F00D, 1, 13, 0, 5'd25, 5'd26, 5'd27);
    chk("lit_lw_data", last_data, 32'hCAFE_F00D);
    chk("lit_lw_lat", 32'(last_lat), 32'd18);

    do_op(OP_SW, 32'h208, 32'h1122_3344, 32'h0, TMO - 1, 0, 0, 5'd28, 5'd29, 5'd30);
    chk("lit_sw_lat", 32'(last_lat), 32'd17);
    chk("lit_sw_err", 32'(last_err), 32'd0);
    chk("lit_sw_wdata", seen_wdata, 32'h1122_3344);
    do_op(OP_SB, 32'h20B, 32'h0000_00A5, 32'h0, TMO, 0, 0, 5'd31, 5'd1, 5'd2);
    chk("lit_sb_tmo_err", 32'(last_err), 32'd1);
    chk("lit_sb_tmo_lat", 32'(last_lat), 32'd17);
    do_op(OP_SB, 32'h209, 32'h1234_5678, 32'h0, 0, 0, 0, 5'd3, 5'd4, 5'd5);
    chk("lit_sb_be", 32'(seen_be), 32'b0010);
    chk("lit_sb_wdata", seen_wdata, 32'h7878_7878);
    do_op(OP_SH, 32'h101, 32'hFFFF, 32'h0, 0, 0, 0, 5'd6, 5'd7, 5'd8);
    chk("lit_sh_mis", 32'(last_mis), 32'd1);
    do_op(OP_LH, 32'h203, 32'h0, 32'h0, 0, 0, 0, 5'd9, 5'd10, 5'd11);
    do_op(6'd33, 32'hFACE, 32'h0, 32'h0, 0, 0, 0, 5'd12, 5'd13, 5'd14);
    chk("lit_unknown_data", last_data, 32'hFACE);

    // Reset while a load sits in WAIT: everything clears at once, no result.
    wait_ready();
    cur_mem = 1'b1; cur_we = 1'b0; cur_addr = 32'h300; cur_be = 4'hF;
    in_valid = 1'b1; opcode = OP_LW; alu_out = 32'h300;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); mem_gnt = 1'b1;
    @(negedge clk); mem_gnt = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_out_data", out_data, 32'h0);
    chk("arst_out_opcode", 32'(out_opcode), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    cur_mem = 1'b0;
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_op(OP_LB, 32'h304, 32'h0, 32'h0000_007F, 0, 0, 0, 5'd15, 5'd16, 5'd17);
    chk("lit_post_rst_data", last_data, 32'h7F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
